// File: rtl/fake_data_sequencer_pkg.sv
// Shared definitions for the fake-telescope run sequencer.
// Generator mode codes and controller state encoding.
package fake_data_sequencer_pkg;

   localparam logic [1:0] MODE_CONST = 2'b00;
   localparam logic [1:0] MODE_MFSR  = 2'b01;
   localparam logic [1:0] MODE_COUNT = 2'b10;
   localparam logic [1:0] MODE_HOLD  = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_RUN   = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_e;

endpackage

// File: rtl/fake_data_sequencer_if.sv
// Command, generator-control and status bundle for the sequencer.
// master drives commands and generator valid; slave is the sequencer.
interface fake_data_sequencer_if #(
   parameter int CBITS = 16
);
   logic             start_i;
   logic [1:0]       mode_i;
   logic [CBITS-1:0] length_i;
   logic             abort_i;
   logic             valid_i;
   logic             gen_reset_o;
   logic             enable_o;
   logic             shift_o;
   logic             count_o;
   logic             busy_o;
   logic             done_o;
   logic             aborted_o;
   logic             error_o;
   logic [CBITS-1:0] received_o;

   modport master (
      output start_i, mode_i, length_i, abort_i, valid_i,
      input  gen_reset_o, enable_o, shift_o, count_o,
      input  busy_o, done_o, aborted_o, error_o, received_o
   );

   modport slave (
      input  start_i, mode_i, length_i, abort_i, valid_i,
      output gen_reset_o, enable_o, shift_o, count_o,
      output busy_o, done_o, aborted_o, error_o, received_o
   );
endinterface

// File: rtl/fake_data_sequencer_burst_counter.sv
// Loadable down-counter with zero flag.
// Counts the enable cycles still to be issued in RUN.
module burst_counter #(
   parameter int CBITS = 16
) (
   input  logic             clock_i,
   input  logic             reset_ni,
   input  logic             load_i,
   input  logic             dec_i,
   input  logic [CBITS-1:0] value_i,
   output logic             zero_o
);
   logic [CBITS-1:0] cnt_q, cnt_d;

   // load wins over decrement; never wraps below zero
   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = value_i;
      else if (dec_i && cnt_q != '0)
         cnt_d = cnt_q - 1'b1;
   end

   // counter register
   always_ff @(posedge clock_i) begin
      if (!reset_ni) cnt_q <= '0;
      else           cnt_q <= cnt_d;
   end

   assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/fake_data_sequencer.sv
// Burst run-controller for the fake-data generator.
// Issues enables, counts returned samples, flags abort/timeout.
module fake_data_sequencer
   import fake_data_sequencer_pkg::*;
#(
   parameter int CBITS   = 16,
   parameter int LATENCY = 2,
   parameter int TBITS   = 4,
   parameter int TIMEOUT = 8
) (
   input logic                  clock_i,
   input logic                  reset_ni,
   fake_data_sequencer_if.slave bus
);
   state_e           state_q, state_d;
   logic [1:0]       mode_q, mode_d;
   logic [CBITS-1:0] length_q, length_d;
   logic [CBITS-1:0] recv_q, recv_d;
   logic             aborted_q, aborted_d;
   logic             error_q, error_d;
   logic [TBITS-1:0] tmo_q, tmo_d;
   logic [TBITS-1:0] idle_q, idle_d;
   logic             cnt_load, cnt_dec, cnt_zero;
   logic             active, shift_on, count_on;

   burst_counter #(.CBITS(CBITS)) u_issue (
      .clock_i (clock_i),
      .reset_ni(reset_ni),
      .load_i  (cnt_load),
      .dec_i   (cnt_dec),
      .value_i (length_q - 1'b1),
      .zero_o  (cnt_zero)
   );

   // next state, latched command, sample and drain counters
   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      length_d  = length_q;
      recv_d    = recv_q;
      aborted_d = aborted_q;
      error_d   = error_q;
      tmo_d     = '0;
      idle_d    = '0;
      cnt_load  = 1'b0;
      cnt_dec   = 1'b0;
      if (bus.valid_i && recv_q != '1 &&
          (state_q == S_RUN || state_q == S_DRAIN))
         recv_d = recv_q + 1'b1;
      unique case (state_q)
         S_IDLE: begin
            if (bus.start_i) begin
               mode_d    = bus.mode_i;
               length_d  = bus.length_i;
               recv_d    = '0;
               aborted_d = 1'b0;
               error_d   = 1'b0;
               state_d   = S_SETUP;
            end
         end
         S_SETUP: begin
            cnt_load = 1'b1;
            if (bus.abort_i) begin
               aborted_d = 1'b1;
               state_d   = S_DRAIN;
            end else if (length_q == '0) begin
               state_d = S_DONE;
            end else begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (bus.abort_i) begin
               aborted_d = 1'b1;
               state_d   = S_DRAIN;
            end else if (cnt_zero) begin
               state_d = S_DRAIN;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         S_DRAIN: begin
            tmo_d  = tmo_q + 1'b1;
            idle_d = bus.valid_i ? '0 : idle_q + 1'b1;
            if (recv_q == length_q) begin
               state_d = S_DONE;
            end else if (aborted_q &&
                         idle_d == TBITS'(LATENCY)) begin
               state_d = S_DONE;
            end else if (tmo_d == TBITS'(TIMEOUT)) begin
               error_d = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // state and status registers
   always_ff @(posedge clock_i) begin
      if (!reset_ni) begin
         state_q   <= S_IDLE;
         mode_q    <= MODE_CONST;
         length_q  <= '0;
         recv_q    <= '0;
         aborted_q <= 1'b0;
         error_q   <= 1'b0;
         tmo_q     <= '0;
         idle_q    <= '0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         length_q  <= length_d;
         recv_q    <= recv_d;
         aborted_q <= aborted_d;
         error_q   <= error_d;
         tmo_q     <= tmo_d;
         idle_q    <= idle_d;
      end
   end

   assign active   = (state_q == S_SETUP) ||
                     (state_q == S_RUN) ||
                     (state_q == S_DRAIN);
   assign shift_on = (mode_q == MODE_MFSR) ||
                     (mode_q == MODE_HOLD);
   assign count_on = (mode_q == MODE_COUNT) ||
                     (mode_q == MODE_HOLD);

   assign bus.gen_reset_o = (state_q == S_SETUP);
   assign bus.enable_o    = (state_q == S_RUN);
   assign bus.shift_o     = active && shift_on;
   assign bus.count_o     = active && count_on;
   assign bus.busy_o      = (state_q != S_IDLE);
   assign bus.done_o      = (state_q == S_DONE);
   assign bus.aborted_o   = aborted_q;
   assign bus.error_o     = error_q;
   assign bus.received_o  = recv_q;
endmodule

// File: tb/tb_fake_data_sequencer.sv
// Bench for fake_data_sequencer with a latency-2 generator model.
// Burst table plus hand sequences for reset and ignored inputs.
module tb_fake_data_sequencer;
   import fake_data_sequencer_pkg::*;

   localparam int CB = 16;
   localparam int LAT = 2;

   typedef struct {
      logic [1:0] mode;
      int         len;
      int         abort_t;
      int         ign_t;
      bit         kill;
      int         exp_done;
      int         exp_recv;
      int         exp_en;
      int         exp_err;
      int         exp_abt;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic kill = 1'b0;
   logic [LAT-1:0] gen_pipe = '0;
   int checks = 0;
   int errors = 0;
   vec_t vecs[7];
   vec_t sb[$];

   fake_data_sequencer_if #(.CBITS(CB)) bus ();

   fake_data_sequencer #(
      .CBITS(CB), .LATENCY(LAT), .TBITS(4), .TIMEOUT(8)
   ) dut (
      .clock_i (clk),
      .reset_ni(rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // generator model: valid follows enable by LAT cycles
   always @(posedge clk) begin
      if (bus.gen_reset_o) gen_pipe <= '0;
      else gen_pipe <= {gen_pipe[LAT-2:0], bus.enable_o};
   end
   assign bus.valid_i = gen_pipe[LAT-1] & ~kill;

   task automatic chk(input string nm, input int act,
                      input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d",
                  nm, act, exp);
      end
   endtask

   function automatic vec_t mk(
      input logic [1:0] m, input int l, input int ab,
      input int ig, input bit k, input int d,
      input int r, input int en, input int er, input int ba);
      vec_t v;
      v.mode = m; v.len = l; v.abort_t = ab;
      v.ign_t = ig; v.kill = k; v.exp_done = d;
      v.exp_recv = r; v.exp_en = en;
      v.exp_err = er; v.exp_abt = ba;
      return v;
   endfunction

   task automatic run_burst(input vec_t v);
      vec_t e;
      int done_t = 0;
      int en_n = 0;
      int gr_n = 0;
      int mb = 0;
      @(negedge clk);
      kill = v.kill;
      bus.mode_i = v.mode;
      bus.length_i = CB'(v.len);
      bus.start_i = 1'b1;
      sb.push_back(v);
      for (int t = 1; t <= 300 && done_t == 0; t++) begin
         @(negedge clk);
         bus.start_i = 1'b0;
         bus.abort_i = 1'b0;
         if (t == 1) begin
            chk("clr_error", bus.error_o, 0);
            chk("clr_abort", bus.aborted_o, 0);
            chk("clr_recv", bus.received_o, 0);
         end
         en_n += int'(bus.enable_o);
         gr_n += int'(bus.gen_reset_o);
         if (bus.done_o) begin
            done_t = t;
            if (bus.shift_o || bus.count_o) mb++;
         end else if (bus.shift_o !== v.mode[0] ||
                      bus.count_o !== v.mode[1] ||
                      !bus.busy_o) begin
            mb++;
         end
         if (t == v.abort_t) bus.abort_i = 1'b1;
         if (t == v.ign_t) begin
            bus.start_i = 1'b1;
            bus.mode_i = ~v.mode;
            bus.length_i = CB'(7);
         end
      end
      if (sb.size() == 0) begin
         chk("sb_empty", 0, 1);
      end else begin
         e = sb.pop_front();
         chk("done_cycle", done_t, e.exp_done);
         chk("received", bus.received_o, e.exp_recv);
         chk("error", bus.error_o, e.exp_err);
         chk("aborted", bus.aborted_o, e.exp_abt);
         chk("enable_cycles", en_n, e.exp_en);
         chk("gen_reset_cycles", gr_n, 1);
         chk("mode_outputs", mb, 0);
      end
      @(negedge clk);
      chk("done_single", bus.done_o, 0);
      chk("busy_drop", bus.busy_o, 0);
      chk("idle_mode", {bus.shift_o, bus.count_o}, 0);
      kill = 1'b0;
   endtask

   initial begin
      int dn;
      bus.start_i = 1'b0;
      bus.mode_i = MODE_CONST;
      bus.length_i = '0;
      bus.abort_i = 1'b0;

      vecs[0] = mk(MODE_COUNT, 5, 0, 0, 0, 10, 5, 5, 0, 0);
      vecs[1] = mk(MODE_MFSR, 3, 0, 0, 0, 8, 3, 3, 0, 0);
      vecs[2] = mk(MODE_CONST, 0, 0, 0, 0, 2, 0, 0, 0, 0);
      vecs[3] = mk(MODE_HOLD, 100, 4, 0, 0, 9, 3, 3, 0, 1);
      vecs[4] = mk(MODE_COUNT, 4, 0, 0, 1, 14, 0, 4, 1, 0);
      vecs[5] = mk(MODE_MFSR, 2, 0, 3, 0, 7, 2, 2, 0, 0);
      vecs[6] = mk(MODE_COUNT, 1, 0, 0, 0, 6, 1, 1, 0, 0);

      repeat (3) @(negedge clk);
      chk("rst_busy", bus.busy_o, 0);
      chk("rst_ctrl", {bus.gen_reset_o, bus.enable_o,
                       bus.shift_o, bus.count_o}, 0);
      chk("rst_status", {bus.done_o, bus.aborted_o,
                         bus.error_o}, 0);
      chk("rst_recv", bus.received_o, 0);
      rst_n = 1'b1;

      for (int i = 0; i < 7; i++) run_burst(vecs[i]);

      // reset while running: straight to idle, no done
      @(negedge clk);
      bus.mode_i = MODE_COUNT;
      bus.length_i = CB'(10);
      bus.start_i = 1'b1;
      repeat (3) begin
         @(negedge clk);
         bus.start_i = 1'b0;
      end
      chk("mid_run_enable", bus.enable_o, 1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_busy", bus.busy_o, 0);
      chk("mid_rst_ctrl", {bus.gen_reset_o, bus.enable_o,
                           bus.shift_o, bus.count_o}, 0);
      chk("mid_rst_done", bus.done_o, 0);
      rst_n = 1'b1;
      dn = 0;
      bus.abort_i = 1'b1;
      repeat (6) begin
         @(negedge clk);
         dn += int'(bus.done_o);
      end
      bus.abort_i = 1'b0;
      chk("mid_rst_no_done", dn, 0);
      chk("idle_valid_recv", bus.received_o, 0);
      chk("idle_abort", bus.aborted_o, 0);
      chk("idle_busy", bus.busy_o, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
